// File: rtl/kpn_pkg.sv
// Shared constants and types for the KPN channel read engine.
package kpn_pkg;

  localparam int BITS_NUMBER_DEF = 16;
  localparam int COUNT_BITS_DEF  = 16;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Buffer slots committed after this edge: held tokens plus the returning read, minus the one leaving.
  function automatic logic [2:0] credits_used(occ_e occ, logic inflight, logic pop);
    return {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  endfunction

endpackage

// File: rtl/kpn_fifo_reader_if.sv
// FIFO read port plus consumer valid/ready channel of the KPN reader.
interface kpn_fifo_reader_if
  import kpn_pkg::*;
#(
  parameter int BITS_NUMBER = BITS_NUMBER_DEF
);
  logic                   fifo_rd;
  logic                   fifo_empty;
  logic [BITS_NUMBER-1:0] fifo_data;
  logic [BITS_NUMBER-1:0] token_data;
  logic                   token_valid;
  logic                   token_ready;

  modport master (
    output fifo_rd, token_data, token_valid,
    input  fifo_empty, fifo_data, token_ready
  );

  modport slave (
    input  fifo_rd, token_data, token_valid,
    output fifo_empty, fifo_data, token_ready
  );
endinterface

// File: rtl/kpn_skid_buffer.sv
// Two-entry head/tail token buffer presenting the head on a valid/ready port.
module kpn_skid_buffer
  import kpn_pkg::*;
#(
  parameter int W = BITS_NUMBER_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output occ_e         occ_o
);

  occ_e         occ_q, occ_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         pop;

  assign valid_o = (occ_q != OCC_EMPTY);
  assign data_o  = head_q;
  assign occ_o   = occ_q;
  assign pop     = valid_o & ready_i;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    case (occ_q)
      OCC_EMPTY: begin
        if (push_i) begin
          head_d = data_i;
          occ_d  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        case ({push_i, pop})
          2'b11: head_d = data_i;
          2'b10: begin
            tail_d = data_i;
            occ_d  = OCC_FULL;
          end
          2'b01: occ_d = OCC_EMPTY;
          default: ;
        endcase
      end
      OCC_FULL: begin
        // The credit rule keeps push without pop from ever landing here.
        if (pop) begin
          head_d = tail_q;
          if (push_i) tail_d = data_i;
          else        occ_d  = OCC_ONE;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q  <= OCC_EMPTY;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

endmodule

// File: rtl/kpn_fifo_reader.sv
// Blocking-read engine: credit-gated FIFO reads into a skid buffer, plus channel statistics.
module kpn_fifo_reader
  import kpn_pkg::*;
#(
  parameter int BITS_NUMBER = BITS_NUMBER_DEF,
  parameter int COUNT_BITS  = COUNT_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  kpn_fifo_reader_if.master     bus,
  output logic [COUNT_BITS-1:0] tokens_read,
  output logic [COUNT_BITS-1:0] stall_cycles
);

  logic                   inflight_q, inflight_d;
  logic [COUNT_BITS-1:0]  tokens_q, tokens_d;
  logic [COUNT_BITS-1:0]  stall_q, stall_d;
  logic [BITS_NUMBER-1:0] head;
  logic                   valid;
  occ_e                   occ;
  logic                   pop;
  logic                   credit_ok;
  logic                   rd;
  logic                   stall_hit;

  assign pop       = valid & bus.token_ready;
  assign credit_ok = (credits_used(occ, inflight_q, pop) < 3'd2);
  assign rd        = enable & ~bus.fifo_empty & ~reset & credit_ok;
  assign stall_hit = enable & bus.fifo_empty & (occ != OCC_FULL);

  assign inflight_d = rd;
  assign tokens_d   = tokens_q + {{(COUNT_BITS-1){1'b0}}, pop};
  assign stall_d    = stall_q + {{(COUNT_BITS-1){1'b0}}, stall_hit};

  // Reset clears inflight, so data returning for a pre-reset read is never pushed.
  kpn_skid_buffer #(.W(BITS_NUMBER)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .push_i  (inflight_q),
    .data_i  (bus.fifo_data),
    .ready_i (bus.token_ready),
    .data_o  (head),
    .valid_o (valid),
    .occ_o   (occ)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q <= 1'b0;
      tokens_q   <= '0;
      stall_q    <= '0;
    end else begin
      inflight_q <= inflight_d;
      tokens_q   <= tokens_d;
      stall_q    <= stall_d;
    end
  end

  assign bus.fifo_rd     = rd;
  assign bus.token_data  = head;
  assign bus.token_valid = valid;
  assign tokens_read     = tokens_q;
  assign stall_cycles    = stall_q;

endmodule
